// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latches hall/cabin requests and serves them with a
// SCAN policy, with timed travel, door dwell/hold, and an emergency-stop freeze.
module elevator_ctrl_n #(
    parameter int FLOORS        = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3,
    localparam int FW           = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] f_req,
    input  logic [FLOORS-1:0] c_req,
    input  logic              door_hold,
    input  logic              estop,
    output logic [FLOORS-1:0] pending,
    output logic [FW-1:0]     current_floor,
    output logic              direction,
    output logic              moving,
    output logic              door_open
);

    localparam int CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic              dir_q, dir_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [FLOORS-1:0] req;
    logic [FLOORS-1:0] here_mask, above_mask, below_mask;
    logic              at_here, above, below, new_here;

    always_comb begin
        req        = f_req | c_req;
        here_mask  = '0;
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < FLOORS; i++) begin
            here_mask[i]  = (floor_q == FW'(i));
            above_mask[i] = (FW'(i) > floor_q);
            below_mask[i] = (FW'(i) < floor_q);
        end
        at_here  = |(pending_q & here_mask);
        above    = |(pending_q & above_mask);
        below    = |(pending_q & below_mask);
        new_here = |(req & here_mask);

        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;

        // A press for the floor whose door is already open is absorbed, not queued.
        if (state_q == DOOR) begin
            pending_d = pending_q | (req & ~here_mask);
        end else begin
            pending_d = pending_q | req;
        end

        if (!estop) begin
            case (state_q)
                IDLE: begin
                    if (at_here) begin
                        state_d   = DOOR;
                        pending_d = pending_d & ~here_mask;
                        cnt_d     = CW'(DOOR_CYCLES);
                    end else if (above && (dir_q || !below)) begin
                        state_d = MOVING;
                        dir_d   = 1'b1;
                        cnt_d   = CW'(TRAVEL_CYCLES);
                    end else if (below && (!dir_q || !above)) begin
                        state_d = MOVING;
                        dir_d   = 1'b0;
                        cnt_d   = CW'(TRAVEL_CYCLES);
                    end
                end
                MOVING: begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (dir_q && (floor_q != FW'(FLOORS - 1))) begin
                            floor_d = floor_q + FW'(1);
                        end else if (!dir_q && (floor_q != '0)) begin
                            floor_d = floor_q - FW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                DOOR: begin
                    if (door_hold || new_here) begin
                        cnt_d = CW'(DOOR_CYCLES);
                    end else if (cnt_q <= CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            floor_q   <= '0;
            dir_q     <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending       = pending_q;
    assign current_floor = floor_q;
    assign direction     = dir_q;
    assign moving        = (state_q == MOVING);
    assign door_open     = (state_q == DOOR);

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n: an edge-indexed vector table for the 8-floor
// build plus hand sequences for door hold, absorption, reset, and a 5-floor build.
module tb_elevator_ctrl_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] f_req = '0, c_req = '0;
    logic       door_hold = 1'b0, estop = 1'b0;
    logic [7:0] pending;
    logic [2:0] current_floor;
    logic       direction, moving, door_open;

    logic [4:0] f_req5 = '0, c_req5 = '0;
    logic [4:0] pending5;
    logic [2:0] current_floor5;
    logic       direction5, moving5, door_open5;

    int checks = 0;
    int errors = 0;
    int e = -1;

    elevator_ctrl_n #(.FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .f_req(f_req), .c_req(c_req),
        .door_hold(door_hold), .estop(estop), .pending(pending),
        .current_floor(current_floor), .direction(direction),
        .moving(moving), .door_open(door_open)
    );

    elevator_ctrl_n #(.FLOORS(5), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .f_req(f_req5), .c_req(c_req5),
        .door_hold(1'b0), .estop(1'b0), .pending(pending5),
        .current_floor(current_floor5), .direction(direction5),
        .moving(moving5), .door_open(door_open5)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && current_floor5 >= 3'd5) begin
            errors++;
            $display("FAIL floor5_range: current_floor=%0d required <5", current_floor5);
        end
    end

    typedef struct {
        int         e;
        logic [7:0] f;
        logic [7:0] c;
        logic       hold;
        logic       es;
        logic [2:0] fl;
        logic       dir;
        logic       mov;
        logic       door;
        logic [7:0] pend;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int ed, input logic [7:0] f, input logic [7:0] c,
                       input logic h, input logic s, input logic [2:0] fl,
                       input logic dr, input logic mv, input logic dor, input logic [7:0] p);
        vec_t v;
        v.e = ed; v.f = f; v.c = c; v.hold = h; v.es = s;
        v.fl = fl; v.dir = dr; v.mov = mv; v.door = dor; v.pend = p;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] snap();
        return {18'd0, current_floor, direction, moving, door_open, pending};
    endfunction

    function automatic logic [31:0] pk(input logic [2:0] fl, input logic dr, input logic mv,
                                       input logic dor, input logic [7:0] p);
        return {18'd0, fl, dr, mv, dor, p};
    endfunction

    initial begin
        // edge, f_req, c_req, hold, estop -> floor, dir, moving, door, pending
        add(  0, 8'h00, 8'h08, 0, 0, 3'd0, 1, 0, 0, 8'h08);
        add(  1, 8'h00, 8'h00, 0, 0, 3'd0, 1, 1, 0, 8'h08);
        add(  4, 8'h00, 8'h00, 0, 0, 3'd0, 1, 1, 0, 8'h08);
        add(  5, 8'h00, 8'h00, 0, 0, 3'd1, 1, 0, 0, 8'h08);
        add(  6, 8'h00, 8'h00, 0, 0, 3'd1, 1, 1, 0, 8'h08);
        add( 10, 8'h00, 8'h00, 0, 0, 3'd2, 1, 0, 0, 8'h08);
        add( 15, 8'h00, 8'h00, 0, 0, 3'd3, 1, 0, 0, 8'h08);
        add( 16, 8'h00, 8'h00, 0, 0, 3'd3, 1, 0, 1, 8'h00);
        add( 18, 8'h00, 8'h00, 0, 0, 3'd3, 1, 0, 1, 8'h00);
        add( 19, 8'h00, 8'h00, 0, 0, 3'd3, 1, 0, 0, 8'h00);
        add( 20, 8'h00, 8'h00, 0, 0, 3'd3, 1, 0, 0, 8'h00);
        add( 21, 8'h00, 8'h10, 0, 0, 3'd3, 1, 0, 0, 8'h10);
        add( 22, 8'h00, 8'h00, 0, 0, 3'd3, 1, 1, 0, 8'h10);
        add( 26, 8'h00, 8'h00, 0, 0, 3'd4, 1, 0, 0, 8'h10);
        add( 27, 8'h00, 8'h00, 0, 0, 3'd4, 1, 0, 1, 8'h00);
        add( 30, 8'h00, 8'h00, 0, 0, 3'd4, 1, 0, 0, 8'h00);
        add( 31, 8'h44, 8'h00, 0, 0, 3'd4, 1, 0, 0, 8'h44);
        add( 32, 8'h00, 8'h00, 0, 0, 3'd4, 1, 1, 0, 8'h44);
        add( 41, 8'h00, 8'h00, 0, 0, 3'd6, 1, 0, 0, 8'h44);
        add( 42, 8'h00, 8'h00, 0, 0, 3'd6, 1, 0, 1, 8'h04);
        add( 45, 8'h00, 8'h00, 0, 0, 3'd6, 1, 0, 0, 8'h04);
        add( 46, 8'h00, 8'h00, 0, 0, 3'd6, 0, 1, 0, 8'h04);
        add( 50, 8'h00, 8'h00, 0, 0, 3'd5, 0, 0, 0, 8'h04);
        add( 51, 8'h80, 8'h00, 0, 0, 3'd5, 0, 1, 0, 8'h84);
        add( 55, 8'h00, 8'h00, 0, 0, 3'd4, 0, 0, 0, 8'h84);
        add( 56, 8'h00, 8'h00, 0, 0, 3'd4, 0, 1, 0, 8'h84);
        add( 65, 8'h00, 8'h00, 0, 0, 3'd2, 0, 0, 0, 8'h84);
        add( 66, 8'h00, 8'h00, 0, 0, 3'd2, 0, 0, 1, 8'h80);
        add( 69, 8'h00, 8'h00, 0, 0, 3'd2, 0, 0, 0, 8'h80);
        add( 70, 8'h00, 8'h00, 0, 0, 3'd2, 1, 1, 0, 8'h80);
        add( 72, 8'h00, 8'h00, 0, 0, 3'd2, 1, 1, 0, 8'h80);
        add( 73, 8'h00, 8'h40, 0, 1, 3'd2, 1, 1, 0, 8'hC0);
        add( 82, 8'h00, 8'h00, 0, 1, 3'd2, 1, 1, 0, 8'hC0);
        add( 83, 8'h00, 8'h00, 0, 0, 3'd2, 1, 1, 0, 8'hC0);
        add( 84, 8'h00, 8'h00, 0, 0, 3'd3, 1, 0, 0, 8'hC0);
        add( 99, 8'h00, 8'h00, 0, 0, 3'd6, 1, 0, 0, 8'hC0);
        add(100, 8'h00, 8'h00, 0, 0, 3'd6, 1, 0, 1, 8'h80);
        add(103, 8'h00, 8'h00, 0, 0, 3'd6, 1, 0, 0, 8'h80);
        add(104, 8'h00, 8'h00, 0, 0, 3'd6, 1, 1, 0, 8'h80);
        add(108, 8'h00, 8'h00, 0, 0, 3'd7, 1, 0, 0, 8'h80);
        add(109, 8'h00, 8'h00, 0, 0, 3'd7, 1, 0, 1, 8'h00);
        add(112, 8'h00, 8'h00, 0, 0, 3'd7, 1, 0, 0, 8'h00);

        #3 rst_n = 1'b0;
        tick();
        tick();
        check("reset_state", snap(), pk(3'd0, 1'b1, 1'b0, 1'b0, 8'h00));
        check("reset_state5", {22'd0, current_floor5, direction5, moving5, door_open5, pending5},
              {22'd0, 3'd0, 1'b1, 1'b0, 1'b0, 5'h00});
        rst_n = 1'b1;
        e = -1;

        for (int i = 0; i < tbl.size(); i++) begin
            f_req = tbl[i].f; c_req = tbl[i].c;
            door_hold = tbl[i].hold; estop = tbl[i].es;
            while (e < tbl[i].e) tick();
            check($sformatf("vec%0d_edge%0d", i, tbl[i].e), snap(),
                  pk(tbl[i].fl, tbl[i].dir, tbl[i].mov, tbl[i].door, tbl[i].pend));
        end
        f_req = '0; c_req = '0; door_hold = 1'b0; estop = 1'b0;

        // Door hold at floor 7: five held cycles, then three dwell cycles.
        c_req = 8'h80; tick(); c_req = '0;
        check("hold_latch", {24'd0, pending}, 32'h80);
        tick();
        check("hold_open", {31'd0, door_open}, 32'd1);
        door_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("hold_cyc%0d", k), {31'd0, door_open}, 32'd1);
        end
        door_hold = 1'b0;
        tick(); check("hold_dwell1", {31'd0, door_open}, 32'd1);
        tick(); check("hold_dwell2", {31'd0, door_open}, 32'd1);
        tick(); check("hold_close", {31'd0, door_open}, 32'd0);

        // Same-floor press while open is absorbed and restarts the dwell.
        c_req = 8'h80; tick(); c_req = '0;
        tick(); check("absorb_open", {31'd0, door_open}, 32'd1);
        f_req = 8'h80; tick(); f_req = '0;
        check("absorb_pending", {23'd0, door_open, pending}, {23'd0, 1'b1, 8'h00});
        tick(); check("absorb_dwell1", {31'd0, door_open}, 32'd1);
        tick(); check("absorb_dwell2", {31'd0, door_open}, 32'd1);
        tick(); check("absorb_close", {23'd0, door_open, pending}, 32'd0);

        // Head down from 7, re-press 7 while departing, then reset mid-travel.
        c_req = 8'h01; tick(); c_req = '0;
        tick();
        check("depart_down", snap(), pk(3'd7, 1'b0, 1'b1, 1'b0, 8'h01));
        f_req = 8'h80; tick(); f_req = '0;
        check("moving_same_floor", snap(), pk(3'd7, 1'b0, 1'b1, 1'b0, 8'h81));
        tick();
        #2 rst_n = 1'b0;
        #1 check("async_reset", snap(), pk(3'd0, 1'b1, 1'b0, 1'b0, 8'h00));
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("post_reset_idle", snap(), pk(3'd0, 1'b1, 1'b0, 1'b0, 8'h00));

        // 5-floor build: up to the top floor, then back to ground.
        e = -1;
        c_req5 = 5'h10; tick(); c_req5 = '0;
        check("f5_latch", {27'd0, pending5}, 32'h10);
        while (e < 20) tick();
        check("f5_top", {27'd0, current_floor5, moving5, door_open5}, {27'd0, 3'd4, 1'b0, 1'b0});
        tick();
        check("f5_top_door", {26'd0, door_open5, pending5}, {26'd0, 1'b1, 5'h00});
        while (e < 24) tick();
        c_req5 = 5'h01; tick(); c_req5 = '0;
        tick();
        check("f5_down", {29'd0, direction5, moving5, door_open5}, {29'd0, 1'b0, 1'b1, 1'b0});
        while (e < 45) tick();
        check("f5_ground", {28'd0, current_floor5, moving5}, {28'd0, 3'd0, 1'b0});
        tick();
        check("f5_ground_door", {26'd0, door_open5, pending5}, {26'd0, 1'b1, 5'h00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
